// File: rtl/motion_step_driver.sv
// Stepper burst driver: turns each accepted direction-FSM command into a bounded
// train of step pulses on both wheels, followed by a settle period.
module motion_step_driver #(
   parameter int unsigned STEP_DIV   = 1000,
   parameter int unsigned STEPS_FWD  = 200,
   parameter int unsigned STEPS_TURN = 50,
   parameter int unsigned SETTLE     = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] state_control,
   input  logic [3:0] movement_sel,
   output logic       step_l,
   output logic       step_r,
   output logic       dir_l,
   output logic       dir_r,
   output logic       busy,
   output logic       done,
   output logic       abort,
   output logic       err_cmd
);

   localparam int unsigned MAX_STEPS = (STEPS_FWD > STEPS_TURN) ? STEPS_FWD : STEPS_TURN;
   localparam int unsigned CNT_W     = $clog2(MAX_STEPS + 1);
   localparam int unsigned DIV_W     = $clog2(STEP_DIV);
   localparam int unsigned SET_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [DIV_W-1:0] PRESC_LAST  = DIV_W'(STEP_DIV - 1);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] LOAD_FWD    = CNT_W'(STEPS_FWD);
   localparam logic [CNT_W-1:0] LOAD_TURN   = CNT_W'(STEPS_TURN);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_SETTLE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DIV_W-1:0] presc_q;
   logic [SET_W-1:0] settle_q;
   logic             step_q;
   logic             dir_l_q;
   logic             dir_r_q;
   logic             busy_q;
   logic             done_q;
   logic             abort_q;
   logic             err_q;

   logic sc_move_c;
   logic sel_legal_c;
   logic accept_c;
   logic illegal_c;
   logic halt_c;

   // Command decode; only meaningful while IDLE
   assign sc_move_c   = (state_control == 2'd1) || (state_control == 2'd2);
   assign sel_legal_c = (movement_sel == 4'd2) || (movement_sel == 4'd3) ||
                        (movement_sel == 4'd4);
   assign accept_c    = sc_move_c && sel_legal_c;
   assign illegal_c   = (state_control == 2'd3) ||
                        (sc_move_c && (movement_sel != 4'd0) && !sel_legal_c);
   assign halt_c      = (state_control == 2'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         presc_q  <= '0;
         settle_q <= '0;
         step_q   <= 1'b0;
         dir_l_q  <= 1'b0;
         dir_r_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         step_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (illegal_c) begin
                  err_q <= 1'b1;
               end
               if (accept_c) begin
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
                  presc_q  <= '0;
                  settle_q <= '0;
                  dir_l_q  <= (movement_sel != 4'd3);
                  dir_r_q  <= (movement_sel != 4'd4);
                  cnt_q    <= (movement_sel == 4'd2) ? LOAD_FWD : LOAD_TURN;
               end
            end
            S_RUN: begin
               // Halt wins over a terminal prescaler: no pulse in the abort cycle
               if (halt_c) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  abort_q <= 1'b1;
                  cnt_q   <= '0;
                  presc_q <= '0;
               end else if (presc_q == PRESC_LAST) begin
                  presc_q <= '0;
                  step_q  <= 1'b1;
                  cnt_q   <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q  <= S_SETTLE;
                     settle_q <= '0;
                  end
               end else begin
                  presc_q <= presc_q + DIV_W'(1);
               end
            end
            S_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  settle_q <= settle_q + SET_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign step_l  = step_q;
   assign step_r  = step_q;
   assign dir_l   = dir_l_q;
   assign dir_r   = dir_r_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign abort   = abort_q;
   assign err_cmd = err_q;

endmodule

// File: tb/tb_motion_step_driver.sv
// Scoreboard bench for motion_step_driver: stimulus queues expected step/done/abort
// events with hand-computed cycle stamps, a monitor pops and compares them.
module tb_motion_step_driver;

   localparam logic [3:0] EV_STEP  = 4'b1100;
   localparam logic [3:0] EV_DONE  = 4'b0010;
   localparam logic [3:0] EV_ABORT = 4'b0001;

   logic       clk;
   logic       rst;
   logic [1:0] sc;
   logic [3:0] sel;
   logic       step_l, step_r, dir_l, dir_r, busy, done, abort, err_cmd;

   typedef struct {
      logic [3:0] code;
      int         cyc;
      logic       dl;
      logic       dr;
      logic       busy;
      logic       err;
   } ev_t;

   ev_t exp_q[$];
   ev_t mon_obs;
   ev_t mon_exp;
   int  cyc;
   int  checks;
   int  errors;
   int  c0;

   motion_step_driver #(
      .STEP_DIV  (4),
      .STEPS_FWD (3),
      .STEPS_TURN(2),
      .SETTLE    (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .state_control(sc),
      .movement_sel (sel),
      .step_l       (step_l),
      .step_r       (step_r),
      .dir_l        (dir_l),
      .dir_r        (dir_r),
      .busy         (busy),
      .done         (done),
      .abort        (abort),
      .err_cmd      (err_cmd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_ev(input logic [3:0] code, input int c, input logic dl,
                          input logic dr, input logic b, input logic e);
      ev_t ev;
      ev.code = code;
      ev.cyc  = c;
      ev.dl   = dl;
      ev.dr   = dr;
      ev.busy = b;
      ev.err  = e;
      exp_q.push_back(ev);
   endtask

   task automatic chk(input string name, input logic act, input logic expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_step_l"}, step_l, 1'b0);
      chk({tag, "_step_r"}, step_r, 1'b0);
      chk({tag, "_dir_l"}, dir_l, 1'b0);
      chk({tag, "_dir_r"}, dir_r, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_abort"}, abort, 1'b0);
      chk({tag, "_err"}, err_cmd, 1'b0);
   endtask

   // Present a command for one cycle, then drop movement_sel; c0 stamps the apply cycle
   task automatic run_cmd(input logic [1:0] s, input logic [3:0] m, output int c_start);
      @(posedge clk);
      #1;
      sc      = s;
      sel     = m;
      c_start = cyc;
      @(posedge clk);
      #1;
      sel = 4'd0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
   endtask

   // Monitor: every visible pulse must match the head of the expected queue
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && (step_l || step_r || done || abort)) begin
            mon_obs.code = {step_l, step_r, done, abort};
            mon_obs.cyc  = cyc;
            mon_obs.dl   = dir_l;
            mon_obs.dr   = dir_r;
            mon_obs.busy = busy;
            mon_obs.err  = err_cmd;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got code=%b at cyc %0d, expected no event",
                        mon_obs.code, mon_obs.cyc);
            end else begin
               mon_exp = exp_q.pop_front();
               if (mon_obs.code !== mon_exp.code || mon_obs.cyc != mon_exp.cyc ||
                   mon_obs.dl !== mon_exp.dl || mon_obs.dr !== mon_exp.dr ||
                   mon_obs.busy !== mon_exp.busy || mon_obs.err !== mon_exp.err) begin
                  errors++;
                  $display("FAIL event: got code=%b cyc=%0d dir=%b%b busy=%b err=%b, expected code=%b cyc=%0d dir=%b%b busy=%b err=%b",
                           mon_obs.code, mon_obs.cyc, mon_obs.dl, mon_obs.dr, mon_obs.busy,
                           mon_obs.err, mon_exp.code, mon_exp.cyc, mon_exp.dl, mon_exp.dr,
                           mon_exp.busy, mon_exp.err);
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      sc  = 2'd0;
      sel = 4'd0;
      @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(10);
      #1;
      chk("idle_busy", busy, 1'b0);

      // Forward: steps at RUN cycles 4,8,12 appear one cycle later, done after 2 settle cycles
      run_cmd(2'd1, 4'd2, c0);
      push_ev(EV_STEP, c0 + 5, 1'b1, 1'b1, 1'b1, 1'b0);
      push_ev(EV_STEP, c0 + 9, 1'b1, 1'b1, 1'b1, 1'b0);
      push_ev(EV_STEP, c0 + 13, 1'b1, 1'b1, 1'b1, 1'b0);
      push_ev(EV_DONE, c0 + 15, 1'b1, 1'b1, 1'b0, 1'b0);
      #1;
      chk("fwd_busy_rise", busy, 1'b1);
      idle_cycles(20);

      // Rotate left, then rotate right
      run_cmd(2'd2, 4'd3, c0);
      push_ev(EV_STEP, c0 + 5, 1'b0, 1'b1, 1'b1, 1'b0);
      push_ev(EV_STEP, c0 + 9, 1'b0, 1'b1, 1'b1, 1'b0);
      push_ev(EV_DONE, c0 + 11, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_cycles(16);
      chk("rotl_dir_hold_l", dir_l, 1'b0);
      chk("rotl_dir_hold_r", dir_r, 1'b1);

      run_cmd(2'd2, 4'd4, c0);
      push_ev(EV_STEP, c0 + 5, 1'b1, 1'b0, 1'b1, 1'b0);
      push_ev(EV_STEP, c0 + 9, 1'b1, 1'b0, 1'b1, 1'b0);
      push_ev(EV_DONE, c0 + 11, 1'b1, 1'b0, 1'b0, 1'b0);
      idle_cycles(16);

      // Halt on RUN cycle 8, which is a terminal prescaler cycle
      run_cmd(2'd1, 4'd2, c0);
      push_ev(EV_STEP, c0 + 5, 1'b1, 1'b1, 1'b1, 1'b0);
      push_ev(EV_ABORT, c0 + 9, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_cycles(7);
      #1;
      sc = 2'd0;
      idle_cycles(12);
      #1;
      chk("abort_busy_low", busy, 1'b0);

      // Illegal selector sets sticky error, no burst
      run_cmd(2'd1, 4'd7, c0);
      idle_cycles(3);
      #1;
      chk("err_set", err_cmd, 1'b1);
      chk("err_no_burst", busy, 1'b0);
      run_cmd(2'd2, 4'd4, c0);
      push_ev(EV_STEP, c0 + 5, 1'b1, 1'b0, 1'b1, 1'b1);
      push_ev(EV_STEP, c0 + 9, 1'b1, 1'b0, 1'b1, 1'b1);
      push_ev(EV_DONE, c0 + 11, 1'b1, 1'b0, 1'b0, 1'b1);
      idle_cycles(16);
      #1;
      chk("err_sticky", err_cmd, 1'b1);
      sc  = 2'd0;
      sel = 4'd0;
      #2;
      rst = 1'b1;
      #1;
      chk("err_cleared", err_cmd, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset mid-RUN after the first pulse
      run_cmd(2'd1, 4'd2, c0);
      push_ev(EV_STEP, c0 + 5, 1'b1, 1'b1, 1'b1, 1'b0);
      idle_cycles(6);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("midrun_rst");
      sc  = 2'd0;
      sel = 4'd0;
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(20);

      // Selector wiggles during RUN must not alter direction or step count
      run_cmd(2'd2, 4'd3, c0);
      push_ev(EV_STEP, c0 + 5, 1'b0, 1'b1, 1'b1, 1'b0);
      push_ev(EV_STEP, c0 + 9, 1'b0, 1'b1, 1'b1, 1'b0);
      push_ev(EV_DONE, c0 + 11, 1'b0, 1'b1, 1'b0, 1'b0);
      sel = 4'd4;
      idle_cycles(3);
      #1;
      sel = 4'd2;
      idle_cycles(3);
      #1;
      sel = 4'd0;
      idle_cycles(16);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_events: got %0d still pending, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
